// File: rtl/fp_cmp_sel16.sv
// fp_cmp_sel16: two-stage select of one half-precision compare condition bit
// from the comparator vector, with per-operation and sticky exception flags.
module fp_cmp_sel16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] cmp_vec,
   input  logic        nan,
   input  logic        snan,
   input  logic [3:0]  cond,
   input  logic [7:0]  tag_i,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        res,
   output logic [7:0]  tag_o,
   output logic [1:0]  fflags,
   input  logic        flag_clr
);

   logic        s1_valid;
   logic [15:0] s1_vec;
   logic        s1_nan;
   logic        s1_snan;
   logic [3:0]  s1_cond;
   logic [7:0]  s1_tag;

   logic        s2_inv;
   logic        s2_ill;

   logic        s2_free;
   logic        s1_load;
   logic        s1_move;
   logic        retire;

   logic        s1_legal;
   logic        s1_res;
   logic        s1_inv;

   assign s2_free  = ~out_valid | out_ready;
   assign in_ready = ce & (~s1_valid | s2_free);
   assign s1_load  = in_ready & in_valid;
   assign s1_move  = ce & s2_free;
   assign retire   = ce & out_valid & out_ready;

   // Legal codes are 0-4 and 8-12, so only the low three bits matter.
   assign s1_legal = (s1_cond[2:0] <= 3'd4);
   assign s1_res   = s1_legal & s1_vec[s1_cond];
   // Ordered lt/le/mag-lt (and complements) signal on any NaN.
   assign s1_inv   = s1_snan |
                     (s1_nan & ~s1_cond[2] & (|s1_cond[1:0]));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_vec   <= '0;
         s1_nan   <= 1'b0;
         s1_snan  <= 1'b0;
         s1_cond  <= '0;
         s1_tag   <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_vec  <= cmp_vec;
            s1_nan  <= nan;
            s1_snan <= snan;
            s1_cond <= cond;
            s1_tag  <= tag_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         res       <= 1'b0;
         tag_o     <= '0;
         s2_inv    <= 1'b0;
         s2_ill    <= 1'b0;
      end else if (s1_move) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            res    <= s1_res;
            tag_o  <= s1_tag;
            s2_inv <= s1_inv;
            s2_ill <= ~s1_legal;
         end
      end
   end

   // Clear first, then OR in the retiring result so a new set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fflags <= '0;
      end else if (ce) begin
         fflags <= (flag_clr ? 2'b00 : fflags) |
                   (retire ? {s2_ill, s2_inv} : 2'b00);
      end
   end

   logic unused_ok;
   assign unused_ok = s1_load;

endmodule

// File: tb/tb_fp_cmp_sel16.sv
// tb_fp_cmp_sel16: scoreboard bench for fp_cmp_sel16 with directed
// scenarios and randomized traffic against a condition-table model.
module tb_fp_cmp_sel16;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] cmp_vec;
   logic        nan;
   logic        snan;
   logic [3:0]  cond;
   logic [7:0]  tag_i;
   logic        out_valid;
   logic        out_ready;
   logic        res;
   logic [7:0]  tag_o;
   logic [1:0]  fflags;
   logic        flag_clr;

   fp_cmp_sel16 dut (
      .clk(clk), .rst(rst), .ce(ce),
      .in_valid(in_valid), .in_ready(in_ready),
      .cmp_vec(cmp_vec), .nan(nan), .snan(snan),
      .cond(cond), .tag_i(tag_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .tag_o(tag_o),
      .fflags(fflags), .flag_clr(flag_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r;
      logic [7:0] tag;
      logic [1:0] fl;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic [1:0] exp_ff = 2'b00;
   bit   rand_en = 1'b0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] mk_vec(logic [4:0] lo);
      return {3'b000, ~lo, 3'b000, lo};
   endfunction

   function automatic exp_t model(logic [15:0] v, logic n, logic s,
                                  logic [3:0] c, logic [7:0] t);
      exp_t e;
      int   ci;
      bit   legal;
      bit   inv;
      ci    = int'(c);
      legal = (ci <= 4) || (ci >= 8 && ci <= 12);
      inv   = s || (n && (ci inside {1, 2, 3, 9, 10, 11}));
      e.r   = legal ? v[ci] : 1'b0;
      e.tag = t;
      e.fl  = {!legal, inv};
      return e;
   endfunction

   // Monitor: pops the scoreboard on each handshake and tracks fflags.
   logic       stall_v = 1'b0;
   logic       stall_r;
   logic [7:0] stall_t;
   always @(negedge clk) begin
      exp_t e;
      logic [1:0] bits;
      if (rst) begin
         exp_ff  = 2'b00;
         stall_v = 1'b0;
      end else begin
         chk("fflags", 32'(fflags), 32'(exp_ff));
         if (stall_v) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_res", 32'(res), 32'(stall_r));
            chk("stall_tag", 32'(tag_o), 32'(stall_t));
         end
         bits = 2'b00;
         if (ce && out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 32'(tag_o), 32'hFFFF_FFFF);
            end else begin
               e = q.pop_front();
               chk("res", 32'(res), 32'(e.r));
               chk("tag", 32'(tag_o), 32'(e.tag));
               bits = e.fl;
            end
         end
         if (ce) exp_ff = (flag_clr ? 2'b00 : exp_ff) | bits;
         stall_v = out_valid && !(ce && out_ready);
         stall_r = res;
         stall_t = tag_o;
      end
   end

   always @(posedge clk) begin
      if (rand_en) begin
         #1;
         ce       = ($urandom % 10) != 0;
         out_ready = ($urandom % 3) != 0;
         flag_clr = ($urandom % 8) == 0;
      end
   end

   task automatic issue(logic [15:0] v, logic n, logic s,
                        logic [3:0] c, logic [7:0] t);
      cmp_vec  = v;
      nan      = n;
      snan     = s;
      cond     = c;
      tag_i    = t;
      in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(model(v, n, s, c, t));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      chk("issue_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (q.size() == 0) break;
      end
      chk("drain", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      flag_clr = 1'b1;
      @(posedge clk);
      #1;
      flag_clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ce = 1'b0; in_valid = 1'b0; cmp_vec = '0;
      nan = 1'b0; snan = 1'b0; cond = '0; tag_i = '0;
      out_ready = 1'b1; flag_clr = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_tag", 32'(tag_o), 32'd0);
      chk("rst_fflags", 32'(fflags), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ce  = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Unstalled compare with latency check
      issue(16'h110E, 1'b0, 1'b0, 4'd1, 8'h5A);
      @(negedge clk);
      chk("lat_early", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("lat_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
      chk("ff_031", 32'(fflags), 32'd0);

      // Quiet NaN on signalling and quiet relations
      issue(16'h0F10, 1'b1, 1'b0, 4'd1, 8'h11);
      drain();
      chk("ff_032a", 32'(fflags), 32'b01);
      pulse_clr();
      issue(16'h0F10, 1'b1, 1'b0, 4'd0, 8'h12);
      drain();
      chk("ff_032b", 32'(fflags), 32'b00);

      // Illegal condition code, then snan on a quiet relation
      issue(16'h0F10, 1'b0, 1'b0, 4'd5, 8'h13);
      drain();
      chk("ff_033a", 32'(fflags), 32'b10);
      issue(16'h0F10, 1'b1, 1'b1, 4'd12, 8'h14);
      drain();
      chk("ff_033b", 32'(fflags), 32'b11);
      pulse_clr();

      // Back-pressure: two accepted, third waits, then in-order drain
      out_ready = 1'b0;
      issue(16'h110E, 1'b0, 1'b0, 4'd1, 8'd1);
      issue(16'h110E, 1'b0, 1'b0, 4'd8, 8'd2);
      cmp_vec = 16'h110E; nan = 1'b0; snan = 1'b0;
      cond = 4'd2; tag_i = 8'd3; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      issue(16'h110E, 1'b0, 1'b0, 4'd2, 8'd3);
      @(negedge clk);
      chk("bp_tag2", 32'(tag_o), 32'd2);
      @(negedge clk);
      chk("bp_tag3", 32'(tag_o), 32'd3);
      drain();

      // Clear and set on the same retiring edge
      out_ready = 1'b0;
      issue(16'h0F10, 1'b1, 1'b1, 4'd0, 8'h36);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      flag_clr  = 1'b1;
      @(posedge clk);
      #1;
      flag_clr = 1'b0;
      chk("ff_036", 32'(fflags), 32'b01);

      // Reset mid-flight with two operations held
      out_ready = 1'b0;
      issue(16'h110E, 1'b0, 1'b1, 4'd1, 8'h41);
      issue(16'h110E, 1'b0, 1'b0, 4'd1, 8'h42);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_fflags", 32'(fflags), 32'd0);
      q.delete();
      #10;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("rst_mid_ready", 32'(in_ready), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rst_no_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      // Randomized traffic with ce, out_ready and flag_clr noise
      rand_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [4:0] lo;
         logic       n;
         lo = 5'($urandom);
         n  = ($urandom % 4) == 0;
         issue(mk_vec(lo), n, n & ($urandom % 2 == 0),
               4'($urandom_range(0, 15)), 8'(i));
      end
      rand_en = 1'b0;
      @(posedge clk);
      #1;
      ce = 1'b1;
      out_ready = 1'b1;
      flag_clr = 1'b0;
      drain();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
